// File: rtl/reset_sequencer.sv
// System reset sequencer: button synchronizer and debouncer, minimum-length reset stretch,
// and supervision of the core trap (sticky halt or timed auto-restart).
module reset_sequencer #(
  parameter int unsigned RESET_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES  = 3000,
  parameter int unsigned TRAP_RESTART     = 0,
  parameter int unsigned TRAP_WAIT_CYCLES = 3000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       trap,
  output logic       power_on_reset,
  output logic       trap_led,
  output logic [7:0] restart_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StRun     = 2'd1,
    StTrapped = 2'd2
  } state_e;

  localparam int unsigned HoldW = $clog2(RESET_CYCLES);
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned WaitW = $clog2(TRAP_WAIT_CYCLES + 1);

  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_CYCLES - 1);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TRAP_WAIT_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_db_q, btn_db_d;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic             pressed_s;

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             trap_led_q, trap_led_d;
  logic [7:0]       restart_q, restart_d;
  logic [7:0]       restart_inc;

  assign pressed_s = ~sync_q[1];

  // A mismatch must persist for DEBOUNCE_CYCLES consecutive samples before btn_db follows.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (pressed_s != btn_db_q) begin
      if (db_cnt_q == DbLast) begin
        btn_db_d = ~btn_db_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  assign restart_inc = (restart_q == 8'hFF) ? restart_q : restart_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    wait_cnt_d = wait_cnt_q;
    trap_led_d = trap_led_q;
    restart_d  = restart_q;
    case (state_q)
      StHold: begin
        if (btn_db_q) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldLast) begin
          hold_cnt_d = '0;
          state_d    = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StRun: begin
        if (btn_db_q) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end else if (trap) begin
          state_d    = StTrapped;
          wait_cnt_d = '0;
          trap_led_d = 1'b1;
        end
      end
      StTrapped: begin
        if (btn_db_q) begin
          state_d    = StHold;
          hold_cnt_d = '0;
          trap_led_d = 1'b0;
          restart_d  = restart_inc;
        end else if (TRAP_RESTART != 0) begin
          if (wait_cnt_q == WaitLast) begin
            state_d    = StHold;
            hold_cnt_d = '0;
            wait_cnt_d = '0;
            restart_d  = restart_inc;
          end else begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
        end
      end
      default: begin
        state_d    = StHold;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= 2'b11;
      btn_db_q   <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= StHold;
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
      trap_led_q <= 1'b0;
      restart_q  <= 8'd0;
    end else begin
      sync_q     <= {sync_q[0], btn_n};
      btn_db_q   <= btn_db_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      trap_led_q <= trap_led_d;
      restart_q  <= restart_d;
    end
  end

  assign power_on_reset = (state_q == StHold);
  assign trap_led       = trap_led_q;
  assign restart_count  = restart_q;
  assign state          = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: one halting instance and one auto-restarting instance.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_n0, trap0, btn_n1, trap1;
  logic       por0, led0, por1, led1;
  logic [7:0] rc0, rc1;
  logic [1:0] state0, state1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .RESET_CYCLES(4), .DEBOUNCE_CYCLES(4), .TRAP_RESTART(0), .TRAP_WAIT_CYCLES(10)
  ) u_halt (
    .clk(clk), .reset(reset), .btn_n(btn_n0), .trap(trap0),
    .power_on_reset(por0), .trap_led(led0), .restart_count(rc0), .state(state0)
  );

  reset_sequencer #(
    .RESET_CYCLES(4), .DEBOUNCE_CYCLES(4), .TRAP_RESTART(1), .TRAP_WAIT_CYCLES(10)
  ) u_auto (
    .clk(clk), .reset(reset), .btn_n(btn_n1), .trap(trap1),
    .power_on_reset(por1), .trap_led(led1), .restart_count(rc1), .state(state1)
  );

  // Advance n rising edges, then settle 1 time unit before sampling or driving.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int bad;
    reset = 1'b1; btn_n0 = 1'b1; btn_n1 = 1'b1; trap0 = 1'b0; trap1 = 1'b0;
    tick(2);
    chk("rst_state0", int'(state0), 0);
    chk("rst_por0", int'(por0), 1);
    chk("rst_led0", int'(led0), 0);
    chk("rst_rc0", int'(rc0), 0);
    chk("rst_state1", int'(state1), 0);
    reset = 1'b0;

    // Reset stretch: exactly 4 cycles high after release.
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk("por_stretch", int'(por0), 1);
    end
    tick(1);
    chk("por_release", int'(por0), 0);
    chk("run_state0", int'(state0), 1);
    chk("run_led0", int'(led0), 0);
    chk("run_rc0", int'(rc0), 0);
    chk("run_state1", int'(state1), 1);

    // 3-cycle glitch must be filtered.
    btn_n0 = 1'b0; tick(3); btn_n0 = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (por0 !== 1'b0 || state0 !== 2'd1) bad++;
    end
    chk("glitch_filtered", bad, 0);

    // Held press: rises on edge 7, falls 10 edges after release.
    btn_n0 = 1'b0;
    tick(6);
    chk("press_edge6", int'(por0), 0);
    tick(1);
    chk("press_edge7", int'(por0), 1);
    tick(13);
    chk("press_held_por", int'(por0), 1);
    chk("press_held_state", int'(state0), 0);
    btn_n0 = 1'b1;
    tick(9);
    chk("release_edge9", int'(por0), 1);
    tick(1);
    chk("release_edge10", int'(por0), 0);
    chk("release_state", int'(state0), 1);

    // Halt on trap.
    trap0 = 1'b1; tick(1); trap0 = 1'b0;
    chk("trap_state", int'(state0), 2);
    chk("trap_led", int'(led0), 1);
    chk("trap_por", int'(por0), 0);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (por0 !== 1'b0 || state0 !== 2'd2 || led0 !== 1'b1) bad++;
    end
    chk("trap_halt_1000", bad, 0);

    // Button exit from TRAPPED clears led, counts a restart.
    btn_n0 = 1'b0;
    tick(6);
    chk("trap_btn_edge6", int'(state0), 2);
    tick(1);
    chk("trap_btn_state", int'(state0), 0);
    chk("trap_btn_led", int'(led0), 0);
    chk("trap_btn_rc", int'(rc0), 1);
    btn_n0 = 1'b1;
    tick(10);
    chk("trap_btn_run", int'(state0), 1);
    chk("trap_btn_rc_kept", int'(rc0), 1);

    // Trap and debounced button arrive together: button wins.
    btn_n0 = 1'b0;
    tick(6);
    chk("sim_edge6", int'(state0), 1);
    trap0 = 1'b1;
    tick(1);
    chk("sim_state", int'(state0), 0);
    chk("sim_led", int'(led0), 0);
    trap0 = 1'b0; btn_n0 = 1'b1;
    tick(10);
    chk("sim_run", int'(state0), 1);
    chk("sim_rc", int'(rc0), 1);

    // Auto-restart: 10 cycles TRAPPED, 4 cycles HOLD, back to RUN.
    trap1 = 1'b1;
    tick(1);
    chk("auto_trap_state", int'(state1), 2);
    chk("auto_trap_led", int'(led1), 1);
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      if (state1 !== 2'd2) bad++;
    end
    chk("auto_trapped_10", bad, 0);
    tick(1);
    chk("auto_hold_state", int'(state1), 0);
    chk("auto_hold_por", int'(por1), 1);
    chk("auto_hold_rc", int'(rc1), 1);
    chk("auto_hold_led", int'(led1), 1);
    tick(3);
    chk("auto_hold_edge4", int'(state1), 0);
    tick(1);
    chk("auto_run_state", int'(state1), 1);
    chk("auto_run_rc", int'(rc1), 1);
    tick(60);
    chk("auto_rc5", int'(rc1), 5);
    chk("auto_rc5_state", int'(state1), 1);
    tick(3);
    chk("auto_rc5_trapped", int'(state1), 2);

    // Reset mid-episode wipes everything.
    reset = 1'b1;
    tick(1);
    chk("midrst_state", int'(state1), 0);
    chk("midrst_por", int'(por1), 1);
    chk("midrst_led", int'(led1), 0);
    chk("midrst_rc", int'(rc1), 0);
    reset = 1'b0;

    // From release, restart k completes on edge 15k.
    tick(15 * 254);
    chk("sat_rc254", int'(rc1), 254);
    chk("sat_rc254_state", int'(state1), 0);
    tick(15 * 6);
    chk("sat_rc255", int'(rc1), 255);
    chk("sat_led", int'(led1), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
